// File: rtl/popeye_dl_router.sv
// rtl/popeye_dl_router.sv - ioctl download demux, DIP/mod capture and core reset sequencing (option: POPEYE_DL_CHECKSUM_EN)
module popeye_dl_router #(
  parameter int         ROM_BYTES    = 81920,
  parameter int         RESET_HOLD   = 16,
  parameter logic [7:0] DIP_DEFAULT0 = 8'h00,
  parameter logic [7:0] DIP_DEFAULT1 = 8'hC2,
  parameter logic [7:0] DIP_DEFAULT2 = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dl_addr,
  output logic        dl_wr,
  output logic [7:0]  dl_data,
  output logic [7:0]  dip_sw0,
  output logic [7:0]  dip_sw1,
  output logic [7:0]  dip_sw2,
  output logic        mod_skyskipr,
  output logic        core_reset,
  output logic        rom_loading,
  output logic        dl_done,
`ifdef POPEYE_DL_CHECKSUM_EN
  output logic [15:0] dl_sum,
  output logic [16:0] dl_count,
`endif
  output logic        dl_overflow
);

  localparam int          CW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(RESET_HOLD - 1);
  localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOADING} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] hold_cnt;

  logic rom_start;
  logic rom_sel;
  logic in_range;
  logic rom_accept;
  logic rom_over;
  logic enter_loading;
  logic leave_loading;
  logic dip_hit;

  // Decode of the incoming ioctl cycle; only index 0 steers the FSM
  always_comb begin
    rom_start     = ioctl_download && (ioctl_index == 8'd0);
    rom_sel       = (state == S_LOADING) && ioctl_wr && (ioctl_index == 8'd0);
    in_range      = (ioctl_addr < ROM_LIMIT);
    rom_accept    = rom_sel && in_range;
    rom_over      = rom_sel && !in_range;
    enter_loading = (state != S_LOADING) && (next_state == S_LOADING);
    leave_loading = (state == S_LOADING) && (next_state == S_HOLD);
    dip_hit       = ioctl_wr && (ioctl_index == 8'd254) &&
                    (ioctl_addr[24:3] == 22'd0) && (ioctl_addr[2:0] < 3'd3);
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_HOLD;
    else       state <= next_state;
  end

  // Next-state logic: a ROM download start beats the hold counter expiring
  always_comb begin
    next_state = state;
    case (state)
      S_HOLD: begin
        if (rom_start)            next_state = S_LOADING;
        else if (hold_cnt == '0)  next_state = S_RUN;
      end
      S_RUN: begin
        if (rom_start) next_state = S_LOADING;
      end
      S_LOADING: begin
        if (!ioctl_download) next_state = S_HOLD;
      end
      default: next_state = S_HOLD;
    endcase
  end

  // Outputs decoded from the current state so core_reset rises with LOADING
  always_comb begin
    core_reset  = (state != S_RUN);
    rom_loading = (state == S_LOADING);
  end

  // Hold counter: reloaded when a download ends, counts down while holding
  always_ff @(posedge clk_sys) begin
    if (reset)                              hold_cnt <= HOLD_RELOAD;
    else if (leave_loading)                 hold_cnt <= HOLD_RELOAD;
    else if (state == S_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
  end

  // Registered ROM write port, completion pulse and sticky overflow flag
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_wr       <= 1'b0;
      dl_addr     <= '0;
      dl_data     <= '0;
      dl_done     <= 1'b0;
      dl_overflow <= 1'b0;
    end else begin
      dl_wr   <= rom_accept;
      dl_done <= leave_loading;
      if (rom_accept) begin
        dl_addr <= ioctl_addr[16:0];
        dl_data <= ioctl_dout;
      end
      if (enter_loading)  dl_overflow <= 1'b0;
      else if (rom_over)  dl_overflow <= 1'b1;
    end
  end

  // DIP banks and board-mod flag, writable in every state
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dip_sw0      <= DIP_DEFAULT0;
      dip_sw1      <= DIP_DEFAULT1;
      dip_sw2      <= DIP_DEFAULT2;
      mod_skyskipr <= 1'b0;
    end else begin
      if (dip_hit) begin
        case (ioctl_addr[1:0])
          2'd0:    dip_sw0 <= ioctl_dout;
          2'd1:    dip_sw1 <= ioctl_dout;
          default: dip_sw2 <= ioctl_dout;
        endcase
      end
      if (ioctl_wr && ioctl_index == 8'd1) mod_skyskipr <= |ioctl_dout;
    end
  end

`ifdef POPEYE_DL_CHECKSUM_EN
  // Running sum and saturating byte count of accepted ROM bytes
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_sum   <= '0;
      dl_count <= '0;
    end else if (enter_loading) begin
      dl_sum   <= '0;
      dl_count <= '0;
    end else if (rom_accept) begin
      dl_sum <= dl_sum + {8'd0, ioctl_dout};
      if (dl_count != '1) dl_count <= dl_count + 17'd1;
    end
  end
`endif

endmodule
